ex_mul_seq: RTL and testbench

//  Multi-cycle sequencer for the EX-stage multiply operations (ALU_MUL, ALU_MULHU).
//  It replaces the single-cycle combinational 32x32 multiply with an iterative

---
 rtl/ex_pkg.sv | 10 +
 rtl/ex_mul_seq_step.sv | 12 +
 rtl/ex_mul_seq.sv | 85 ++++++++
 tb/tb_ex_mul_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared types and defaults for the EX-stage multiply sequencer
package ex_pkg;
  typedef enum logic [1:0] {MS_IDLE, MS_BUSY, MS_DONE} mul_state_t;
  localparam int DEF_XLEN = 32;
  localparam int DEF_BPC = 2;
  localparam int MUL_STEPS = DEF_XLEN / DEF_BPC;
  localparam logic [4:0] ALU_ADD = 5'h00;
  localparam logic [4:0] ALU_MUL = 5'h0A;
  localparam logic [4:0] ALU_MULHU = 5'h0D;
endpackage

// File: rtl/ex_mul_seq_step.sv
// mul_step: one shift-add iteration, acc + opa_sh * digit
module mul_step #(
  parameter int XLEN = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [2*XLEN-1:0]         i_acc,
  input  logic [2*XLEN-1:0]         i_opa_sh,
  input  logic [BITS_PER_CYCLE-1:0] i_digit,
  output logic [2*XLEN-1:0]         o_acc
);
  assign o_acc = i_acc + i_opa_sh * {{(2*XLEN-BITS_PER_CYCLE){1'b0}}, i_digit};
endmodule

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: iterative shift-add MUL/MULHU sequencer that stalls the front of the pipeline
module ex_mul_seq
  import ex_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int BITS_PER_CYCLE = DEF_BPC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_ex_valid_inst,
  input  logic [4:0]      id_ex_alu_func,
  input  logic [XLEN-1:0] mul_opa,
  input  logic [XLEN-1:0] mul_opb,
  input  logic            ex_flush,
  output logic            ex_stall_out,
  output logic            mul_done,
  output logic [XLEN-1:0] mul_result
);
  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(STEPS + 1);
  if (XLEN % BITS_PER_CYCLE != 0) begin : g_bpc_err
    $error("BITS_PER_CYCLE must divide XLEN");
  end
  mul_state_t        r_state;
  logic [2*XLEN-1:0] r_acc, r_opa_sh, w_acc_next;
  logic [XLEN-1:0]   r_opb_sh, r_result;
  logic [CW-1:0]     r_count;
  logic              r_sel_hi, r_done, w_req, w_last;
  assign w_req = id_ex_valid_inst & ~ex_flush &
                 (id_ex_alu_func == ALU_MUL | id_ex_alu_func == ALU_MULHU);
  assign w_last = r_count == CW'(STEPS - 1);
  assign ex_stall_out = ~rst & ((r_state == MS_IDLE) ? w_req : (r_state == MS_BUSY) & ~ex_flush);
  assign mul_done = r_done;
  assign mul_result = r_result;
  mul_step #(.XLEN(XLEN), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .i_acc(r_acc),
    .i_opa_sh(r_opa_sh),
    .i_digit(r_opb_sh[BITS_PER_CYCLE-1:0]),
    .o_acc(w_acc_next)
  );
  // flush outranks both a new request and the final accumulate step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MS_IDLE;
      r_acc <= '0;
      r_opa_sh <= '0;
      r_opb_sh <= '0;
      r_count <= '0;
      r_sel_hi <= 1'b0;
      r_done <= 1'b0;
      r_result <= '0;
    end else if (ex_flush) begin
      r_state <= MS_IDLE;
      r_count <= '0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        MS_IDLE: if (w_req) begin
          r_state <= MS_BUSY;
          r_acc <= '0;
          r_opa_sh <= {{XLEN{1'b0}}, mul_opa};
          r_opb_sh <= mul_opb;
          r_sel_hi <= id_ex_alu_func == ALU_MULHU;
          r_count <= '0;
        end
        MS_BUSY: begin
          r_acc <= w_acc_next;
          r_opa_sh <= r_opa_sh << BITS_PER_CYCLE;
          r_opb_sh <= r_opb_sh >> BITS_PER_CYCLE;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_state <= MS_DONE;
            r_done <= 1'b1;
            r_result <= r_sel_hi ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
          end
        end
        MS_DONE: begin
          r_state <= MS_IDLE;
          r_done <= 1'b0;
        end
        default: r_state <= MS_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_mul_seq.sv
// tb_ex_mul_seq: directed self-checking bench for ex_mul_seq
module tb_ex_mul_seq;
  import ex_pkg::*;
  logic        clk = 0, rst = 1, valid = 0, flush = 0;
  logic [4:0]  func = ALU_ADD;
  logic [31:0] opa = 0, opb = 0;
  logic        ex_stall_out, mul_done;
  logic [31:0] mul_result;
  int checks = 0, failures = 0;

  ex_mul_seq dut (
    .clk(clk), .rst(rst), .id_ex_valid_inst(valid), .id_ex_alu_func(func),
    .mul_opa(opa), .mul_opb(opb), .ex_flush(flush),
    .ex_stall_out(ex_stall_out), .mul_done(mul_done), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ex_stall_out !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", ex_stall_out); end
    checks++; if (mul_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", mul_done); end
    checks++; if (mul_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", mul_result); end
    rst = 0;
  endtask

  // cycle 0 = request cycle; operands scrambled during BUSY must not matter
  task automatic run_mul(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    valid = 1; func = f; opa = a; opb = b;
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c < 17) begin opa = a ^ 32'hA5A50000 ^ c; opb = ~b + c; end
        else valid = 0;
      end
      @(negedge clk);
      checks++; if (ex_stall_out !== (c <= 16)) begin failures++; $display("FAIL %s_stall c=%0d got=%b exp=%b", nm, c, ex_stall_out, c <= 16); end
      checks++; if (mul_done !== (c == 17)) begin failures++; $display("FAIL %s_done c=%0d got=%b exp=%b", nm, c, mul_done, c == 17); end
      if (c == 17) begin
        checks++; if (mul_result !== exp) begin failures++; $display("FAIL %s_result got=%h exp=%h", nm, mul_result, exp); end
      end
    end
  endtask

  task automatic test_basic();
    run_mul(ALU_MUL, 32'd3, 32'd5, 32'h0000000F, "mul3x5");
  endtask

  task automatic test_extremes();
    run_mul(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ones");
    run_mul(ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_ones");
    run_mul(ALU_MUL, 32'h12345678, 32'h0, 32'h0, "mul_zero");
    run_mul(ALU_MULHU, 32'h80000000, 32'd2, 32'h00000001, "mulhu_carry");
  endtask

  task automatic test_non_mul();
    @(posedge clk); #1;
    valid = 1; func = ALU_ADD; opa = 7; opb = 9;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (ex_stall_out !== 1'b0 || mul_done !== 1'b0) begin failures++; $display("FAIL nonmul c=%0d stall=%b done=%b exp=0/0", c, ex_stall_out, mul_done); end
    end
    @(posedge clk); #1;
    valid = 0;
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    valid = 1; func = ALU_MUL; opa = 11; opb = 13;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 8) flush = 1;
    end
    @(negedge clk);
    checks++; if (ex_stall_out !== 1'b0) begin failures++; $display("FAIL flush_busy_stall got=%b exp=0", ex_stall_out); end
    @(posedge clk); #1;
    flush = 0; valid = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (ex_stall_out !== 1'b0 || mul_done !== 1'b0) begin failures++; $display("FAIL flush_quiet c=%0d stall=%b done=%b exp=0/0", c, ex_stall_out, mul_done); end
    end
    @(posedge clk); #1;
    valid = 1; func = ALU_MULHU; flush = 1;
    @(negedge clk);
    checks++; if (ex_stall_out !== 1'b0) begin failures++; $display("FAIL flush_idle_stall got=%b exp=0", ex_stall_out); end
    @(posedge clk); #1;
    valid = 0; flush = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (ex_stall_out !== 1'b0 || mul_done !== 1'b0) begin failures++; $display("FAIL flush_idle_quiet c=%0d stall=%b done=%b exp=0/0", c, ex_stall_out, mul_done); end
    end
  endtask

  task automatic test_back_to_back();
    run_mul(ALU_MUL, 32'd7, 32'd6, 32'd42, "b2b_first");
    run_mul(ALU_MUL, 32'd9, 32'd9, 32'd81, "b2b_second");
  endtask

  task automatic test_reset_mid_busy();
    @(posedge clk); #1;
    valid = 1; func = ALU_MUL; opa = 100; opb = 200;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
    end
    rst = 1; valid = 0;
    #1;
    checks++; if (ex_stall_out !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", ex_stall_out); end
    checks++; if (mul_done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", mul_done); end
    checks++; if (mul_result !== 32'h0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", mul_result); end
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (ex_stall_out !== 1'b0 || mul_done !== 1'b0) begin failures++; $display("FAIL rstmid_quiet c=%0d stall=%b done=%b exp=0/0", c, ex_stall_out, mul_done); end
    end
    run_mul(ALU_MUL, 32'd2, 32'd3, 32'd6, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_non_mul();
    test_flush();
    test_back_to_back();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
